// File: rtl/t_vals_tx.sv
// t_vals_tx: transmit end of the T-value handoff into the formant/phi stage.
// Streams one frame of I signed samples, keeps running lag-0..NU_VALUES-1
// autocorrelation sums T(nu) = sum x[n]*x[n-nu], and snapshots the sums at
// each latched segment right-end boundary. A frame produces one start flare
// followed by exactly FORMANTS valid pulses.
//
// Optional feature macro: T_VALS_SATURATE_EN
//   defined   -> accumulator adds clamp to the signed range and stay clamped
//                for the rest of the frame
//   undefined -> plain modulo-2^BIT_WIDTH accumulation
module t_vals_tx #(
    parameter int BIT_WIDTH    = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int I            = 160,
    parameter int FORMANTS     = 5,
    parameter int NU_VALUES    = 3
) (
    input  logic                                        clk_in,
    input  logic                                        rst_n_in,
    input  logic                                        frame_start_in,
    input  logic [FORMANTS-1:0][$clog2(I+1)-1:0]        boundaries_in,
    input  logic signed [SAMPLE_WIDTH-1:0]              sample_in,
    input  logic                                        sample_valid_in,
    output logic [NU_VALUES-1:0][BIT_WIDTH-1:0]         T_vals_out,
    output logic                                        output_start,
    output logic                                        output_valid,
    output logic                                        frame_done_out,
    output logic                                        busy_out,
    output logic                                        err_out
);

    localparam int CW = $clog2(I + 1);
    localparam int KW = $clog2(FORMANTS + 1);
    localparam int PW = 2 * SAMPLE_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                           state_q;
    logic [FORMANTS-1:0][CW-1:0]          bnd_q;
    logic [CW-1:0]                        n_q;
    logic [KW-1:0]                        k_q;
    logic signed [SAMPLE_WIDTH-1:0]       hist_q [NU_VALUES-1];

    // Stage 1 -> stage 2 pipeline
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]  prod_q;
    logic                                 s1_vld_q;
    logic                                 s1_hit_q;
    logic                                 s1_last_q;

    // Stage 2 accumulators and registered outputs
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]  acc_q;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]  tv_q;
    logic                                 start_q;
    logic                                 valid_q;
    logic                                 done_q;
    logic                                 err_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                                 bnd_ok_s;
    logic                                 accept_s;
    logic [CW-1:0]                        n_inc_s;
    logic [CW-1:0]                        b_cur_s;
    logic                                 hit_s;
    logic signed [SAMPLE_WIDTH-1:0]       taps_s [NU_VALUES];
    logic signed [PW-1:0]                 mul_s  [NU_VALUES];
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]  acc_nxt_s;

    // A boundary set is usable only if it is strictly increasing, starts
    // above zero and does not run past the end of the frame.
    function automatic logic check_bounds(input logic [FORMANTS-1:0][CW-1:0] b);
        logic ok;
        ok = (b[0] != {CW{1'b0}});
        for (int j = 1; j < FORMANTS; j++) begin
            ok = ok & (b[j] > b[j-1]);
        end
        ok = ok & (b[FORMANTS-1] <= CW'(I));
        return ok;
    endfunction

    assign bnd_ok_s = check_bounds(boundaries_in);

    // A sample is taken only inside a frame, never past sample I, and never
    // in a cycle that restarts the frame.
    assign accept_s = sample_valid_in && (state_q == ST_ACCUM) &&
                      (n_q != CW'(I)) && !frame_start_in;

    assign n_inc_s = n_q + CW'(1);

    // Select the boundary currently being waited for.
    always_comb begin
        b_cur_s = {CW{1'b0}};
        for (int j = 0; j < FORMANTS; j++) begin
            if (k_q == KW'(j)) begin
                b_cur_s = bnd_q[j];
            end else begin
                b_cur_s = b_cur_s;
            end
        end
    end

    // Once all FORMANTS boundaries have fired the tail produces no pulses.
    assign hit_s = (k_q < KW'(FORMANTS)) && (n_inc_s == b_cur_s);

    // Build the tap vector x[n], x[n-1], ... and the lag products.
    always_comb begin
        taps_s[0] = sample_in;
        for (int j = 1; j < NU_VALUES; j++) begin
            taps_s[j] = hist_q[j-1];
        end
        for (int nu = 0; nu < NU_VALUES; nu++) begin
            mul_s[nu] = taps_s[0] * taps_s[nu];
        end
    end

`ifdef T_VALS_SATURATE_EN
    logic [NU_VALUES-1:0] sat_q;
    logic [NU_VALUES-1:0] sat_d;

    // Signed add with clamp; the MSB of the result flags an overflow.
    function automatic logic [BIT_WIDTH:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                   input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH-1:0] s;
        logic                 ovf;
        logic [BIT_WIDTH:0]   r;
        s   = a + b;
        ovf = (a[BIT_WIDTH-1] == b[BIT_WIDTH-1]) && (s[BIT_WIDTH-1] != a[BIT_WIDTH-1]);
        if (!ovf) begin
            r = {1'b0, s};
        end else if (a[BIT_WIDTH-1]) begin
            r = {1'b1, 1'b1, {(BIT_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(BIT_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // Saturating accumulate; a clamped accumulator holds for the frame.
    always_comb begin
        for (int nu = 0; nu < NU_VALUES; nu++) begin
            if (sat_q[nu]) begin
                acc_nxt_s[nu] = acc_q[nu];
                sat_d[nu]     = 1'b1;
            end else begin
                {sat_d[nu], acc_nxt_s[nu]} = sat_add(acc_q[nu], prod_q[nu]);
            end
        end
    end

    // Sticky saturation flags, cleared at every frame start.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sat_q <= {NU_VALUES{1'b0}};
        end else if (frame_start_in) begin
            sat_q <= {NU_VALUES{1'b0}};
        end else if (s1_vld_q) begin
            sat_q <= sat_d;
        end else begin
            sat_q <= sat_q;
        end
    end
`else
    // Plain wrapping accumulate.
    always_comb begin
        for (int nu = 0; nu < NU_VALUES; nu++) begin
            acc_nxt_s[nu] = acc_q[nu] + prod_q[nu];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 1: products, history shift, sample and segment counters
    // ------------------------------------------------------------------
    // Register the lag products of each accepted sample and advance counters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            n_q       <= {CW{1'b0}};
            k_q       <= {KW{1'b0}};
            prod_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_hit_q  <= 1'b0;
            s1_last_q <= 1'b0;
            for (int j = 0; j < NU_VALUES - 1; j++) begin
                hist_q[j] <= {SAMPLE_WIDTH{1'b0}};
            end
        end else if (frame_start_in) begin
            // Restart: zero history so x[n-nu] reads as 0 for n < nu, and
            // drop whatever the previous frame had in flight.
            n_q       <= {CW{1'b0}};
            k_q       <= {KW{1'b0}};
            s1_vld_q  <= 1'b0;
            s1_hit_q  <= 1'b0;
            s1_last_q <= 1'b0;
            for (int j = 0; j < NU_VALUES - 1; j++) begin
                hist_q[j] <= {SAMPLE_WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            for (int nu = 0; nu < NU_VALUES; nu++) begin
                prod_q[nu] <= BIT_WIDTH'(mul_s[nu]);
            end
            hist_q[0] <= sample_in;
            for (int j = 1; j < NU_VALUES - 1; j++) begin
                hist_q[j] <= hist_q[j-1];
            end
            n_q       <= n_inc_s;
            s1_vld_q  <= 1'b1;
            s1_hit_q  <= hit_s;
            s1_last_q <= (n_inc_s == CW'(I));
            if (hit_s) begin
                k_q <= k_q + KW'(1);
            end else begin
                k_q <= k_q;
            end
        end else begin
            s1_vld_q  <= 1'b0;
            s1_hit_q  <= 1'b0;
            s1_last_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 and control: accumulate, snapshot, pulses, frame state
    // ------------------------------------------------------------------
    // Frame control, accumulation and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            bnd_q   <= '0;
            acc_q   <= '0;
            tv_q    <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (frame_start_in) begin
                if (bnd_ok_s) begin
                    bnd_q   <= boundaries_in;
                    acc_q   <= '0;
                    state_q <= ST_ACCUM;
                    start_q <= 1'b1;
                end else begin
                    err_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            end else if (s1_vld_q) begin
                acc_q <= acc_nxt_s;
                if (s1_hit_q) begin
                    tv_q    <= acc_nxt_s;
                    valid_q <= 1'b1;
                end else begin
                    tv_q    <= tv_q;
                end
                if (s1_last_q) begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end else begin
                    state_q <= state_q;
                end
            end else begin
                acc_q   <= acc_q;
                state_q <= state_q;
            end
        end
    end

    assign T_vals_out     = tv_q;
    assign output_start   = start_q;
    assign output_valid   = valid_q;
    assign frame_done_out = done_q;
    assign busy_out       = (state_q == ST_ACCUM);
    assign err_out        = err_q;

endmodule

// File: tb/tb_t_vals_tx.sv
// Directed self-checking bench for t_vals_tx. Expected values are hand
// computed from the autocorrelation definition for each stimulus frame.
module tb_t_vals_tx;

    localparam int BW = 32;
    localparam int SW = 16;
    localparam int NI = 160;
    localparam int NF = 5;
    localparam int NU = 3;
    localparam int CW = $clog2(NI + 1);

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         fs;
    logic [NF-1:0][CW-1:0]        bnd;
    logic signed [SW-1:0]         smp;
    logic                         sv;
    logic [NU-1:0][BW-1:0]        tv;
    logic                         ostart;
    logic                         ovalid;
    logic                         fdone;
    logic                         busy;
    logic                         err;

    always #5 clk = ~clk;

    t_vals_tx #(
        .BIT_WIDTH   (BW),
        .SAMPLE_WIDTH(SW),
        .I           (NI),
        .FORMANTS    (NF),
        .NU_VALUES   (NU)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .frame_start_in (fs),
        .boundaries_in  (bnd),
        .sample_in      (smp),
        .sample_valid_in(sv),
        .T_vals_out     (tv),
        .output_start   (ostart),
        .output_valid   (ovalid),
        .frame_done_out (fdone),
        .busy_out       (busy),
        .err_out        (err)
    );

    int total = 0;
    int bad   = 0;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and pulse monitor (sampled on the falling edge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BW-1:0] q_t0[$];
    logic [BW-1:0] q_t1[$];
    logic [BW-1:0] q_t2[$];
    int            q_cyc[$];
    int            n_start, n_err, n_done, done_cyc, first_cyc;
    logic          busy_seen;

    always @(negedge clk) begin
        if (ovalid) begin
            q_t0.push_back(tv[0]);
            q_t1.push_back(tv[1]);
            q_t2.push_back(tv[2]);
            q_cyc.push_back(cyc);
        end
        if (ostart) n_start++;
        if (err)    n_err++;
        if (fdone) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
    end

    task automatic clr_mon();
        q_t0.delete(); q_t1.delete(); q_t2.delete(); q_cyc.delete();
        n_start = 0; n_err = 0; n_done = 0; done_cyc = -1; busy_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            fs = 1'b0; sv = 1'b0;
        end
    endtask

    task automatic start_frame(input int b0, input int b1, input int b2, input int b3, input int b4);
        @(posedge clk); #1;
        sv = 1'b0; fs = 1'b1;
        bnd[0] = b0[CW-1:0]; bnd[1] = b1[CW-1:0]; bnd[2] = b2[CW-1:0];
        bnd[3] = b3[CW-1:0]; bnd[4] = b4[CW-1:0];
        @(posedge clk); #1;
        fs = 1'b0;
    endtask

    // mode 0: constant v; mode 1: ramp 1,2,3..; mode 2: +v,-v,+v,...
    task automatic send(input int mode, input int v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i == 0) first_cyc = cyc;
            fs = 1'b0; sv = 1'b1;
            case (mode)
                0:       smp = v[SW-1:0];
                1:       smp = 16'(i + 1);
                2:       smp = (i % 2 == 0) ? 16'(v) : 16'(-v);
                default: smp = 16'sd0;
            endcase
        end
        @(posedge clk); #1;
        sv = 1'b0;
    endtask

    // Constant-sample frame with boundaries 32..160: pulse k carries
    // T0 = m*32k, T1 = m*(32k-1), T2 = m*(32k-2) where m = v*v.
    task automatic check_const(input string tag, input int m);
        check_eq({tag, " pulses"}, 64'(q_t0.size()), 64'd5);
        for (int k = 1; k <= 5; k++) begin
            check_eq($sformatf("%s p%0d T0", tag, k), 64'(q_t0[k-1]), 64'(m * 32 * k));
            check_eq($sformatf("%s p%0d T1", tag, k), 64'(q_t1[k-1]), 64'(m * (32 * k - 1)));
            check_eq($sformatf("%s p%0d T2", tag, k), 64'(q_t2[k-1]), 64'(m * (32 * k - 2)));
        end
        check_eq({tag, " starts"}, 64'(n_start), 64'd1);
        check_eq({tag, " done"}, 64'(n_done), 64'd1);
        check_eq({tag, " done with p5"}, 64'(done_cyc), 64'(q_cyc[4]));
        check_eq({tag, " busy end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; fs = 1'b0; sv = 1'b0; smp = 16'sd0; bnd = '0;
        clr_mon();
        #1;
        check_eq("reset outs", 64'({ostart, ovalid, fdone, busy, err}), 64'd0);
        check_eq("reset T", 64'(tv[0] | tv[1] | tv[2]), 64'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Constant samples = 2
        clr_mon();
        start_frame(32, 64, 96, 128, 160);
        check_eq("flare start", 64'(ostart), 64'd1);
        check_eq("flare busy", 64'(busy), 64'd1);
        send(0, 2, NI);
        idle(4);
        check_const("const", 4);

        // Zero history: ramp 1..160, boundaries 1,2,3,4,160
        clr_mon();
        start_frame(1, 2, 3, 4, 160);
        send(1, 0, NI);
        idle(4);
        check_eq("ramp pulses", 64'(q_t0.size()), 64'd5);
        check_eq("ramp latency", 64'(q_cyc[0]), 64'(first_cyc + 2));
        check_eq("ramp p1", {q_t0[0], q_t1[0] ^ q_t2[0]}, {32'd1, 32'd0});
        check_eq("ramp p2 T", {q_t0[1], q_t1[1]}, {32'd5, 32'd2});
        check_eq("ramp p2 T2", 64'(q_t2[1]), 64'd0);
        check_eq("ramp p3 T", {q_t0[2], q_t1[2]}, {32'd14, 32'd8});
        check_eq("ramp p3 T2", 64'(q_t2[2]), 64'd3);
        check_eq("ramp p4 T", {q_t0[3], q_t1[3]}, {32'd30, 32'd20});
        check_eq("ramp p4 T2", 64'(q_t2[3]), 64'd11);
        check_eq("ramp p5 T0", 64'(q_t0[4]), 64'd1378160);
        check_eq("ramp p5 T1", 64'(q_t1[4]), 64'd1365280);
        check_eq("ramp p5 T2", 64'(q_t2[4]), 64'd1352401);

        // Sign handling: +3,-3,... with back-to-back boundaries 1..5
        clr_mon();
        start_frame(1, 2, 3, 4, 5);
        send(2, 3, NI);
        idle(4);
        check_eq("alt pulses", 64'(q_t0.size()), 64'd5);
        check_eq("alt back2back", 64'(q_cyc[4] - q_cyc[0]), 64'd4);
        check_eq("alt p2 T1", 64'(q_t1[1]), 64'(32'hFFFF_FFF7));
        check_eq("alt p5 T0", 64'(q_t0[4]), 64'd45);
        check_eq("alt p5 T1", 64'(q_t1[4]), 64'(32'hFFFF_FFDC));
        check_eq("alt p5 T2", 64'(q_t2[4]), 64'd27);

        // Rejected boundary sets
        clr_mon();
        start_frame(64, 32, 96, 128, 160);
        idle(1);
        check_eq("bad order err", 64'(n_err), 64'd1);
        start_frame(0, 32, 96, 128, 160);
        idle(1);
        check_eq("bad zero err", 64'(n_err), 64'd2);
        start_frame(32, 64, 96, 128, 161);
        idle(1);
        check_eq("bad over err", 64'(n_err), 64'd3);
        send(0, 2, 20);
        idle(4);
        check_eq("bad no start", 64'(n_start), 64'd0);
        check_eq("bad no busy", 64'(busy_seen), 64'd0);
        check_eq("bad no valid", 64'(q_t0.size() + n_done), 64'd0);

        // Restart after 50 samples of frame A
        clr_mon();
        start_frame(32, 64, 96, 128, 160);
        send(0, 2, 50);
        clr_mon();
        start_frame(32, 64, 96, 128, 160);
        send(0, 3, NI);
        idle(4);
        check_const("restart", 9);

        // Overflow: 32767^2 = 0x3FFF0001 per product
        clr_mon();
        start_frame(2, 3, 4, 5, 160);
        send(0, 32767, NI);
        idle(4);
        check_eq("ovf p1 T0", 64'(q_t0[0]), 64'(32'h7FFE_0002));
`ifdef T_VALS_SATURATE_EN
        check_eq("ovf p2 T0", 64'(q_t0[1]), 64'(32'h7FFF_FFFF));
`else
        check_eq("ovf p2 T0", 64'(q_t0[1]), 64'(32'hBFFD_0003));
`endif
        check_eq("ovf p2 T1", 64'(q_t1[1]), 64'(32'h7FFE_0002));

        // Reset mid-frame after 40 samples
        clr_mon();
        start_frame(32, 64, 96, 128, 160);
        send(0, 2, 40);
        check_eq("pre-reset T0", 64'(tv[0]), 64'd128);
        check_eq("pre-reset busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst outs", 64'({ostart, ovalid, fdone, busy, err}), 64'd0);
        check_eq("midrst T", 64'(tv[0] | tv[1] | tv[2]), 64'd0);
        idle(3);
        rst_n = 1'b1;
        clr_mon();
        send(0, 2, 10);
        idle(10);
        check_eq("post-rst quiet", 64'(q_t0.size() + n_start + n_done), 64'd0);
        clr_mon();
        start_frame(32, 64, 96, 128, 160);
        send(0, 2, NI);
        idle(4);
        check_const("after rst", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
